// File: rtl/calc_pkg.sv
// Shared types and constants for the keypad calculator control path.
package calc_pkg;

   typedef enum logic [2:0] {
      S_CLR    = 3'd0,
      S_WAIT_A = 3'd1,
      S_WAIT_B = 3'd2,
      S_EXEC   = 3'd3,
      S_CAPT   = 3'd4,
      S_RESULT = 3'd5,
      S_ERR    = 3'd6
   } state_t;

   localparam logic FUNC_ADD    = 1'b0;
   localparam logic FUNC_SUB    = 1'b1;
   localparam logic DISP_INPUT  = 1'b0;
   localparam logic DISP_RESULT = 1'b1;

endpackage

// File: rtl/calc_delay_cnt.sv
// Loadable down-counter that times the AU latency between operand B load and result capture.
module calc_delay_cnt #(
   parameter int AU_LATENCY = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic dec,
   output logic zero
);

   localparam int W = (AU_LATENCY > 1) ? $clog2(AU_LATENCY) : 1;

   logic [W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= W'(AU_LATENCY - 1);
      end else if (dec) begin
         cnt <= cnt - W'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/calc_sequencer.sv
// Control FSM for the 8-bit keypad calculator: turns enter/clear pulses into
// one-cycle load strobes, times the AU, supports chaining and a sticky overflow.
module calc_sequencer
   import calc_pkg::*;
#(
   parameter int AU_LATENCY = 2,
   parameter int CHAIN_MAX  = 15,
   parameter int CNT_W      = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             enter_p,
   input  logic             clear_p,
   input  logic             func_in,
   input  logic             ovf_in,
   output logic             load_a,
   output logic             load_b,
   output logic             load_r,
   output logic             a_from_res,
   output logic             func_out,
   output logic             disp_sel,
   output logic             iu_clr,
   output logic             au_clr,
   output logic             ovf_flag,
   output logic [CNT_W-1:0] chain_cnt,
   output logic             busy
);

   state_t state;
   logic   cnt_load;
   logic   cnt_dec;
   logic   cnt_zero;

   assign cnt_load = (state == S_WAIT_B) && enter_p && !clear_p;
   assign cnt_dec  = (state == S_EXEC) && !cnt_zero;

   calc_delay_cnt #(
      .AU_LATENCY(AU_LATENCY)
   ) u_delay (
      .clk (CLK),
      .rst (RST),
      .load(cnt_load),
      .dec (cnt_dec),
      .zero(cnt_zero)
   );

   // Outputs are registered alongside the state so level outputs describe the
   // state being entered and strobes land the cycle after their trigger.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state      <= S_CLR;
         load_a     <= 1'b0;
         load_b     <= 1'b0;
         load_r     <= 1'b0;
         a_from_res <= 1'b0;
         func_out   <= FUNC_ADD;
         disp_sel   <= DISP_INPUT;
         iu_clr     <= 1'b1;
         au_clr     <= 1'b1;
         ovf_flag   <= 1'b0;
         chain_cnt  <= '0;
         busy       <= 1'b1;
      end else begin
         load_a     <= 1'b0;
         load_b     <= 1'b0;
         load_r     <= 1'b0;
         a_from_res <= 1'b0;
         iu_clr     <= 1'b0;
         au_clr     <= 1'b0;
         busy       <= 1'b0;
         disp_sel   <= DISP_INPUT;

         if (clear_p) begin
            state     <= S_CLR;
            iu_clr    <= 1'b1;
            au_clr    <= 1'b1;
            busy      <= 1'b1;
            ovf_flag  <= 1'b0;
            chain_cnt <= '0;
            func_out  <= FUNC_ADD;
         end else begin
            case (state)
               S_CLR: begin
                  state <= S_WAIT_A;
               end
               S_WAIT_A: begin
                  if (enter_p) begin
                     state  <= S_WAIT_B;
                     load_a <= 1'b1;
                     iu_clr <= 1'b1;
                  end
               end
               S_WAIT_B: begin
                  if (enter_p) begin
                     state    <= S_EXEC;
                     load_b   <= 1'b1;
                     func_out <= func_in;
                     iu_clr   <= 1'b1;
                     busy     <= 1'b1;
                  end
               end
               S_EXEC: begin
                  busy <= 1'b1;
                  if (cnt_zero) begin
                     state  <= S_CAPT;
                     load_r <= 1'b1;
                  end
               end
               S_CAPT: begin
                  disp_sel <= DISP_RESULT;
                  if (ovf_in) begin
                     state    <= S_ERR;
                     ovf_flag <= 1'b1;
                  end else begin
                     state <= S_RESULT;
                  end
               end
               S_RESULT: begin
                  disp_sel <= DISP_RESULT;
                  if (enter_p) begin
                     if (chain_cnt < CNT_W'(CHAIN_MAX)) begin
                        state      <= S_WAIT_B;
                        load_a     <= 1'b1;
                        a_from_res <= 1'b1;
                        chain_cnt  <= chain_cnt + CNT_W'(1);
                        disp_sel   <= DISP_INPUT;
                     end else begin
                        // Chain limit reached: restart from a clean slate.
                        state     <= S_CLR;
                        iu_clr    <= 1'b1;
                        au_clr    <= 1'b1;
                        busy      <= 1'b1;
                        disp_sel  <= DISP_INPUT;
                        ovf_flag  <= 1'b0;
                        chain_cnt <= '0;
                        func_out  <= FUNC_ADD;
                     end
                  end
               end
               S_ERR: begin
                  disp_sel <= DISP_RESULT;
               end
               default: begin
                  state  <= S_CLR;
                  iu_clr <= 1'b1;
                  au_clr <= 1'b1;
                  busy   <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer: stimulus pushes expected strobes, a monitor pops and compares them.
module tb_calc_sequencer;
   import calc_pkg::*;

   localparam int AU_LATENCY = 2;
   localparam int CHAIN_MAX  = 15;
   localparam int CNT_W      = 4;

   logic             CLK = 1'b0;
   logic             RST = 1'b1;
   logic             enter_p = 1'b0;
   logic             clear_p = 1'b0;
   logic             func_in = 1'b0;
   logic             ovf_in = 1'b0;
   logic             load_a, load_b, load_r, a_from_res, func_out;
   logic             disp_sel, iu_clr, au_clr, ovf_flag, busy;
   logic [CNT_W-1:0] chain_cnt;

   typedef struct {
      logic [1:0]       kind;
      logic             afr;
      logic             fn;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   lb_cyc = 0;

   calc_sequencer #(
      .AU_LATENCY(AU_LATENCY),
      .CHAIN_MAX (CHAIN_MAX),
      .CNT_W     (CNT_W)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .enter_p   (enter_p),
      .clear_p   (clear_p),
      .func_in   (func_in),
      .ovf_in    (ovf_in),
      .load_a    (load_a),
      .load_b    (load_b),
      .load_r    (load_r),
      .a_from_res(a_from_res),
      .func_out  (func_out),
      .disp_sel  (disp_sel),
      .iu_clr    (iu_clr),
      .au_clr    (au_clr),
      .ovf_flag  (ovf_flag),
      .chain_cnt (chain_cnt),
      .busy      (busy)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check_output(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // One cycle of input drive, starting and ending on a falling edge.
   task automatic apply_stimulus(input logic ent, input logic clr, input logic fn);
      enter_p = ent;
      clear_p = clr;
      func_in = fn;
      @(negedge CLK);
      enter_p = 1'b0;
      clear_p = 1'b0;
   endtask

   task automatic push_exp(input logic [1:0] kind, input logic afr, input logic fn, input int cnt);
      exp_t e;
      e.kind = kind;
      e.afr  = afr;
      e.fn   = fn;
      e.cnt  = CNT_W'(cnt);
      sb.push_back(e);
   endtask

   // A full operation: B load then the result capture, both expected.
   task automatic enter_b(input logic fn, input int cnt);
      push_exp(2'd2, 1'b0, fn, cnt);
      push_exp(2'd3, 1'b0, fn, cnt);
      apply_stimulus(1'b1, 1'b0, fn);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge CLK);
   endtask

   exp_t       mon_e;
   logic [1:0] mon_kind;

   always @(negedge CLK) begin
      if (!RST && (load_a || load_b || load_r)) begin
         check_output("strobe_onehot", int'(load_a) + int'(load_b) + int'(load_r), 1);
         mon_kind = load_a ? 2'd1 : (load_b ? 2'd2 : 2'd3);
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_strobe actual_kind=%0d expected=none", mon_kind);
         end else begin
            mon_e = sb.pop_front();
            check_output("strobe_kind", mon_kind, mon_e.kind);
            check_output("a_from_res", a_from_res, mon_e.afr);
            check_output("func_out", func_out, mon_e.fn);
            check_output("chain_cnt_at_strobe", chain_cnt, mon_e.cnt);
         end
         if (load_b) lb_cyc = cyc;
         if (load_r) check_output("au_latency", cyc - lb_cyc, AU_LATENCY);
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Reset state
      tick(2);
      check_output("rst_iu_clr", iu_clr, 1);
      check_output("rst_au_clr", au_clr, 1);
      check_output("rst_busy", busy, 1);
      check_output("rst_loads", {load_a, load_b, load_r}, 0);
      check_output("rst_chain_cnt", chain_cnt, 0);
      check_output("rst_ovf", ovf_flag, 0);
      RST = 1'b0;
      tick(2);
      check_output("wait_a_busy", busy, 0);
      check_output("wait_a_iu_clr", iu_clr, 0);

      // Basic subtract operation
      push_exp(2'd1, 1'b0, FUNC_ADD, 0);
      apply_stimulus(1'b1, 1'b0, 1'b0);
      check_output("load_a_iu_clr", iu_clr, 1);
      enter_b(FUNC_SUB, 0);
      check_output("exec_busy", busy, 1);
      tick(3);
      check_output("result_disp", disp_sel, DISP_RESULT);
      check_output("result_func", func_out, FUNC_SUB);
      check_output("result_busy", busy, 0);

      // Three chained operations
      for (int k = 1; k <= 3; k++) begin
         push_exp(2'd1, 1'b1, (k == 2) ? 1'b0 : 1'b1, k);
         apply_stimulus(1'b1, 1'b0, 1'b0);
         enter_b((k == 2) ? 1'b1 : 1'b0, k);
         tick(3);
         check_output("chain_cnt", chain_cnt, k);
      end

      // Overflow into the sticky error state
      push_exp(2'd1, 1'b1, 1'b0, 4);
      apply_stimulus(1'b1, 1'b0, 1'b0);
      ovf_in = 1'b1;
      enter_b(1'b0, 4);
      tick(3);
      ovf_in = 1'b0;
      check_output("err_ovf", ovf_flag, 1);
      check_output("err_disp", disp_sel, DISP_RESULT);
      apply_stimulus(1'b1, 1'b0, 1'b0);
      apply_stimulus(1'b1, 1'b0, 1'b0);
      tick(1);
      check_output("err_ovf_held", ovf_flag, 1);
      apply_stimulus(1'b0, 1'b1, 1'b0);
      check_output("clr_ovf", ovf_flag, 0);
      check_output("clr_busy", busy, 1);
      check_output("clr_chain", chain_cnt, 0);
      tick(1);

      // Clear wins over a simultaneous enter in S_WAIT_B
      push_exp(2'd1, 1'b0, 1'b0, 0);
      apply_stimulus(1'b1, 1'b0, 1'b0);
      apply_stimulus(1'b1, 1'b1, 1'b1);
      check_output("clr_prio_busy", busy, 1);
      check_output("clr_prio_au_clr", au_clr, 1);
      tick(1);

      // Saturate the chain counter, with a dropped enter during S_EXEC
      push_exp(2'd1, 1'b0, 1'b0, 0);
      apply_stimulus(1'b1, 1'b0, 1'b0);
      enter_b(1'b0, 0);
      apply_stimulus(1'b1, 1'b0, 1'b0);
      tick(2);
      for (int k = 1; k <= CHAIN_MAX; k++) begin
         push_exp(2'd1, 1'b1, 1'b0, k);
         apply_stimulus(1'b1, 1'b0, 1'b0);
         enter_b(1'b0, k);
         tick(3);
      end
      check_output("chain_sat", chain_cnt, CHAIN_MAX);
      apply_stimulus(1'b1, 1'b0, 1'b0);
      check_output("restart_busy", busy, 1);
      check_output("restart_chain", chain_cnt, 0);
      check_output("restart_iu_clr", iu_clr, 1);
      tick(1);

      // Asynchronous reset in the middle of S_EXEC
      push_exp(2'd1, 1'b0, 1'b0, 0);
      apply_stimulus(1'b1, 1'b0, 1'b0);
      push_exp(2'd2, 1'b0, 1'b1, 0);
      apply_stimulus(1'b1, 1'b0, 1'b1);
      #2 RST = 1'b1;
      #1;
      check_output("midrst_iu_clr", iu_clr, 1);
      check_output("midrst_au_clr", au_clr, 1);
      check_output("midrst_busy", busy, 1);
      check_output("midrst_loads", {load_a, load_b, load_r}, 0);
      @(negedge CLK);
      RST = 1'b0;
      tick(2);
      check_output("midrst_wait_a", busy, 0);
      tick(3);
      check_output("sb_empty", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
